regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (write_enable_flag / a3 / write_data_input) between NUM_REQ write-back requesters, e.g. req 0 = ALU, req 1 = load unit.
- Round-robin arbitration over a valid/ready handshake, with registered outputs that drive the register file directly.
- Holds a 32-entry pending-write scoreboard that the issue stage uses for RAW hazard detection.

Parameters:
NUM_REQ, 2, number of write-back requesters (2..4)
DATA_WIDTH, 32, register data width
ADDR_WIDTH, 5, register address width (32 registers)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a write pending
req_ready  out  NUM_REQ  one-hot grant; handshake = valid & ready
req_rd  in  NUM_REQ*ADDR_WIDTH  destination register per requester, slice i
req_data  in  NUM_REQ*DATA_WIDTH  write data per requester, slice i
rsv_valid  in  1  issue stage reserves rsv_rd this cycle
rsv_rd  in  ADDR_WIDTH  register being reserved
rs1_addr  in  ADDR_WIDTH  source 1 of the instruction at issue
rs2_addr  in  ADDR_WIDTH  source 2 of the instruction at issue
hazard  out  1  combinational: rs1 or rs2 is pending
pending  out  32  scoreboard bits, bit r = write to xr outstanding
write_enable_flag  out  1  registered write enable to the register file
a3  out  ADDR_WIDTH  registered write address
write_data_input  out  DATA_WIDTH  registered write data

Behaviour:
- Reset (async, immediate): write_enable_flag=0, a3=0, write_data_input=0, pending=0, rr pointer=0. req_ready is combinational and is therefore 0 whenever req_valid=0.
- Arbitration (combinational):
  - Among asserted req_valid, grant the first index at or after the rr pointer, wrapping modulo NUM_REQ.
  - Exactly one req_ready is high when any req_valid is high. A port is granted every cycle; there is no backpressure from the register file.
- Pointer update: on a handshake by requester i, the pointer becomes (i+1) mod NUM_REQ at the next edge. With no handshake, the pointer holds.
- Requester rule: once req_valid is raised, req_rd and req_data stay stable until the handshake. The bench checks this.
- Output stage: on the edge after a handshake by requester i:
  - a3 <= req_rd[i]
  - write_data_input <= req_data[i]
  - write_enable_flag <= (req_rd[i] != 0)
  - With no handshake, write_enable_flag <= 0 and a3 / write_data_input hold.
  - The register file commits on the following edge, so total latency from handshake to data visible in the register file is 2 edges.
- x0 handling:
  - A request with rd=0 still completes its handshake, but write_enable_flag stays 0.
  - rsv_valid with rsv_rd=0 is ignored.
  - pending[0] is always 0; hazard never asserts because of a source address of 0.
- Scoreboard, per edge:
  - Clear pending[req_rd[i]] on a handshake by requester i.
  - Set pending[rsv_rd] on rsv_valid.
  - If a set and a clear hit the same register in one cycle, the set wins, because it belongs to the newer producer.
  - A reserve of a register that is already pending leaves the bit set; the first write-back clears it. The issue stage must stall rather than double-reserve, and the bench flags this as a protocol violation.
- hazard = (rs1_addr!=0 & pending[rs1_addr]) | (rs2_addr!=0 & pending[rs2_addr]). It uses the registered pending vector, so it carries no same-cycle bypass from handshakes.
- Reset mid-operation: in-flight writes are dropped. write_enable_flag is forced to 0 asynchronously, so no partial write reaches the register file.

Decomposition:
- Shared package regfile_pkg holds:
  - REG_COUNT=32, ADDR_WIDTH=5, DATA_WIDTH=32
  - constant REG_X0 = 5'd0
  - typedef reg_addr_t (logic [ADDR_WIDTH-1:0])
  - typedef reg_data_t (logic [DATA_WIDTH-1:0])
- Sub-module rr_arbiter (parameter N):
  - Inputs: clk, reset, req[N], advance.
  - Output: one-hot gnt[N].
  - Contains the rotating pointer and is reusable for other shared resources.

Test Plan:
- Reset, then req_valid=0 for 5 cycles -> write_enable_flag=0, pending=0, req_ready=0 throughout.
- req0 valid, rd=5, data=0xDEADBEEF -> req_ready[0]=1 the same cycle; next edge write_enable_flag=1, a3=5, write_data_input=0xDEADBEEF; one-cycle pulse only.
- Both valid every cycle (req0 rd=1, 0x11; req1 rd=2, 0x22), both holding after each grant -> grants alternate 0,1,0,1 starting with 0; no requester waits more than one cycle.
- rsv_valid, rsv_rd=7, then rs1_addr=7 -> hazard=1. req1 write-back rd=7 -> pending[7]=0 next edge and hazard=0. Same-cycle rsv_rd=7 with write-back rd=7 -> pending[7] stays 1.
- req0 rd=0, data=0xFFFFFFFF -> handshake completes, write_enable_flag stays 0. rsv_rd=0 -> pending unchanged. rs1_addr=rs2_addr=0 -> hazard=0.
- Assert reset on the cycle after a handshake -> write_enable_flag drops to 0 without waiting for a clock edge; pending=0 and the pointer returns to 0 after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared register-file constants and types for the write-back path and
//   the issue-stage scoreboard.
//   REG_COUNT  : number of architectural registers (32)
//   ADDR_WIDTH : register address width
//   DATA_WIDTH : register data width
//   REG_X0     : hard-wired zero register; never written, never pending
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int REG_COUNT  = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] REG_X0 = 5'd0;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter with a rotating priority pointer. Grant is
//   combinational; the pointer moves past the granted index on the edge
//   where the caller reports the grant as consumed.
//   clk     : clock
//   reset   : async active-high reset, pointer -> 0
//   req     : request vector
//   advance : grant was used this cycle; move pointer past it
//   gnt     : one-hot grant, zero when no request is present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] cand;
  logic          found;

  // Scan from the pointer upward, wrapping; first valid index wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int off = 0; off < N; off++) begin
      cand = PW'((int'(ptr) + off) % N);
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single register-file write port between NUM_REQ write-back
//   requesters (round-robin, valid/ready) and keeps the pending-write
//   scoreboard the issue stage uses for RAW hazard detection.
//   clk, reset        : clock, async active-high reset
//   req_valid/ready   : per-requester handshake, ready is a one-hot grant
//   req_rd, req_data  : flat per-requester destination / data, slice i
//   rsv_valid, rsv_rd : issue stage reserves a destination register
//   rs1_addr,rs2_addr : sources of the instruction at issue
//   hazard            : a non-x0 source has an outstanding write
//   pending           : scoreboard, bit r = write to xr outstanding
//   write_enable_flag, a3, write_data_input : registered RF write port
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          rsv_valid,
  input  logic [ADDR_WIDTH-1:0]         rsv_rd,
  input  logic [ADDR_WIDTH-1:0]         rs1_addr,
  input  logic [ADDR_WIDTH-1:0]         rs2_addr,
  output logic                          hazard,
  output logic [REG_COUNT-1:0]          pending,
  output logic                          write_enable_flag,
  output logic [ADDR_WIDTH-1:0]         a3,
  output logic [DATA_WIDTH-1:0]         write_data_input
);

  localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(REG_X0);

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] rd_v;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_v;
  logic [NUM_REQ-1:0]                 hs;
  logic                               any_hs;
  logic [ADDR_WIDTH-1:0]              sel_rd;
  logic [DATA_WIDTH-1:0]              sel_data;
  logic [REG_COUNT-1:0]               pend_nxt;

  assign rd_v   = req_rd;
  assign data_v = req_data;

  // The register file never stalls, so every grant is a handshake.
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (any_hs),
    .gnt     (req_ready)
  );

  assign hs     = req_valid & req_ready;
  assign any_hs = |hs;

  // hs is one-hot, so OR-reduction is a mux.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs[i]) begin
        sel_rd   = sel_rd   | rd_v[i];
        sel_data = sel_data | data_v[i];
      end
    end
  end

  // Clear then set: a reserve in the same cycle as a write-back to the
  // same register belongs to the newer producer and must survive.
  always_comb begin
    pend_nxt = pending;
    if (any_hs)
      pend_nxt[sel_rd] = 1'b0;
    if (rsv_valid)
      pend_nxt[rsv_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Uses the registered scoreboard only; no bypass from this cycle's
  // handshakes, the write is not in the register file yet anyway.
  assign hazard = ((rs1_addr != X0) && pending[rs1_addr]) ||
                  ((rs2_addr != X0) && pending[rs2_addr]);

  // Async reset kills the write enable immediately so an in-flight
  // write cannot reach the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_enable_flag <= 1'b0;
      a3                <= '0;
      write_data_input  <= '0;
      pending           <= '0;
    end else begin
      write_enable_flag <= any_hs && (sel_rd != X0);
      if (any_hs) begin
        a3               <= sel_rd;
        write_data_input <= sel_data;
      end
      pending <= pend_nxt;
    end
  end

endmodule
